// File: rtl/system_gpio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : system_gpio_pkg
// Brief    : Register map and parameter encodings shared by the GPIO PIO.
// Revision : 1.0 - initial release
// ============================================================================
package system_gpio_pkg;

    localparam logic [2:0] ADDR_DATA        = 3'd0;
    localparam logic [2:0] ADDR_DIRECTION   = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK     = 3'd2;
    localparam logic [2:0] ADDR_EDGECAPTURE = 3'd3;
    localparam logic [2:0] ADDR_OUTSET      = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR    = 3'd5;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    localparam int IRQ_LEVEL = 0;
    localparam int IRQ_EDGE  = 1;

endpackage
`default_nettype wire

// File: rtl/system_gpio_pio_if.sv
`default_nettype none
// ============================================================================
// Module   : system_gpio_pio_if
// Brief    : Avalon-MM slave bus bundle for the GPIO PIO register file.
// Revision : 1.0 - initial release
// ============================================================================
interface system_gpio_pio_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface
`default_nettype wire

// File: rtl/system_gpio_sync.sv
`default_nettype none
// ============================================================================
// Module   : system_gpio_sync
// Brief    : 2-flop input synchroniser, delay flop and per-bit edge detect.
// Revision : 1.0 - initial release
// ============================================================================
module system_gpio_sync
    import system_gpio_pkg::*;
#(
    parameter int WIDTH     = 19,
    parameter int EDGE_TYPE = EDGE_RISING
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic [WIDTH-1:0] i_async,
    output logic      [WIDTH-1:0] o_sync_in,
    output logic      [WIDTH-1:0] o_edge
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;
    logic [WIDTH-1:0] r_prev;

    // All three stages clear together so a release never looks like an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= '0;
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync_in = r_sync;

    generate
        if (EDGE_TYPE == EDGE_FALLING) begin : g_edge_fall
            assign o_edge = ~r_sync & r_prev;
        end else if (EDGE_TYPE == EDGE_ANY) begin : g_edge_any
            assign o_edge = r_sync ^ r_prev;
        end else begin : g_edge_rise
            assign o_edge = r_sync & ~r_prev;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/system_gpio_pio.sv
`default_nettype none
// ============================================================================
// Module   : system_gpio_pio
// Brief    : Avalon-MM parallel I/O: data/direction/irqmask/edgecapture regs.
// Revision : 1.0 - initial release
// ============================================================================
module system_gpio_pio
    import system_gpio_pkg::*;
#(
    parameter int          WIDTH       = 19,
    parameter logic [31:0] RESET_VALUE = 32'd0,
    parameter int          EDGE_TYPE   = EDGE_RISING,
    parameter int          IRQ_TYPE    = IRQ_EDGE
) (
    input  wire logic             clk,
    input  wire logic             reset,
    system_gpio_pio_if.slave      bus,
    input  wire logic [WIDTH-1:0] in_port,
    output logic      [WIDTH-1:0] out_port,
    output logic      [WIDTH-1:0] oe,
    output logic                  irq
);

    logic [WIDTH-1:0] r_data_out;
    logic [WIDTH-1:0] r_direction;
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] r_edgecapture;
    logic             r_irq;

    logic [WIDTH-1:0] w_sync_in;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_clear;
    logic [WIDTH-1:0] w_irq_src;
    logic [31:0]      w_readdata;
    logic             w_wr_en;

    system_gpio_sync #(
        .WIDTH     (WIDTH),
        .EDGE_TYPE (EDGE_TYPE)
    ) u_sync (
        .clk       (clk),
        .reset     (reset),
        .i_async   (in_port),
        .o_sync_in (w_sync_in),
        .o_edge    (w_edge)
    );

    assign w_wr_en = bus.chipselect & ~bus.write_n;
    assign w_wdata = bus.writedata[WIDTH-1:0];
    assign w_clear = (w_wr_en && (bus.address == ADDR_EDGECAPTURE)) ? w_wdata : '0;

    generate
        if (WIDTH < 32) begin : g_wdata_hi
            logic w_unused_wdata_hi;
            assign w_unused_wdata_hi = ^bus.writedata[31:WIDTH];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data_out  <= RESET_VALUE[WIDTH-1:0];
            r_direction <= '0;
            r_irqmask   <= '0;
        end else if (w_wr_en) begin
            case (bus.address)
                ADDR_DATA:      r_data_out  <= w_wdata;
                ADDR_DIRECTION: r_direction <= w_wdata;
                ADDR_IRQMASK:   r_irqmask   <= w_wdata;
                ADDR_OUTSET:    r_data_out  <= r_data_out | w_wdata;
                ADDR_OUTCLEAR:  r_data_out  <= r_data_out & ~w_wdata;
                default: ;
            endcase
        end
    end

    // A new edge is ORed in after the clear, so set wins on a collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_edgecapture <= '0;
        end else begin
            r_edgecapture <= (r_edgecapture & ~w_clear) | w_edge;
        end
    end

    generate
        if (IRQ_TYPE == IRQ_EDGE) begin : g_irq_edge
            assign w_irq_src = r_edgecapture;
        end else begin : g_irq_level
            assign w_irq_src = w_sync_in;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(w_irq_src & r_irqmask);
        end
    end

    always_comb begin
        w_readdata = '0;
        case (bus.address)
            ADDR_DATA:        w_readdata[WIDTH-1:0] = (w_sync_in & ~r_direction) |
                                                      (r_data_out & r_direction);
            ADDR_DIRECTION:   w_readdata[WIDTH-1:0] = r_direction;
            ADDR_IRQMASK:     w_readdata[WIDTH-1:0] = r_irqmask;
            ADDR_EDGECAPTURE: w_readdata[WIDTH-1:0] = r_edgecapture;
            default: ;
        endcase
    end

    assign bus.readdata = w_readdata;
    assign out_port     = r_data_out;
    assign oe           = r_direction;
    assign irq          = r_irq;

endmodule
`default_nettype wire

// File: doc/system_gpio_pio.md
SYSTEM_GPIO_PIO -- requirements
Module: system_gpio_pio

Interface
REQ-001 The block SHALL have parameter WIDTH, default 19, meaning number of I/O bits (legal 1..32).
REQ-002 The block SHALL have parameter RESET_VALUE, default 0, meaning data_out value after reset (WIDTH bits).
REQ-003 The block SHALL have parameter EDGE_TYPE, default 0, meaning capture edge: 0 rising, 1 falling, 2 any.
REQ-004 The block SHALL have parameter IRQ_TYPE, default 1, meaning irq source: 0 level (synchronised input), 1 edge (capture register).
REQ-005 Clocking and reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-006 Port clk SHALL be an input, 1 bit: the single clock; all registers are posedge clk.
REQ-007 Port reset SHALL be an input, 1 bit: asynchronous active-high reset.
REQ-008 Port address SHALL be an input, 3 bits: Avalon-MM register word select.
REQ-009 Port chipselect SHALL be an input, 1 bit: slave select.
REQ-010 Port write_n SHALL be an input, 1 bit: active-low write strobe, qualified by chipselect.
REQ-011 Port writedata SHALL be an input, 32 bits: write data; bits above WIDTH are ignored.
REQ-012 Port readdata SHALL be an output, 32 bits: read data; bits above WIDTH read 0.
REQ-013 Port in_port SHALL be an input, WIDTH bits: asynchronous external inputs.
REQ-014 Port out_port SHALL be an output, WIDTH bits: registered output data.
REQ-015 Port oe SHALL be an output, WIDTH bits: per-bit output enable (direction register).
REQ-016 Port irq SHALL be an output, 1 bit: active-high interrupt request.

Function
REQ-017 The register map SHALL be: 0 data, 1 direction, 2 irqmask, 3 edgecapture, 4 outset, 5 outclear; addresses 6-7 read 0 and ignore writes.
REQ-018 A write SHALL occur when chipselect=1 and write_n=0, and take effect at the next clk edge.
REQ-019 Reads SHALL be combinational, with zero wait states.
REQ-020 A data read SHALL return (sync_in & ~direction) | (data_out & direction).
REQ-021 A data write SHALL load data_out.
REQ-022 An outset write SHALL perform data_out |= writedata.
REQ-023 An outclear write SHALL perform data_out &= ~writedata.
REQ-024 Addresses 4-5 SHALL read 0.
REQ-025 in_port SHALL pass through a 2-flop synchroniser (sync_in), followed by a third delay flop (prev_in) for edge detection.
REQ-026 The edge signal SHALL be computed per EDGE_TYPE: sync_in & ~prev_in (rising), ~sync_in & prev_in (falling), or sync_in ^ prev_in (any).
REQ-027 Latency from an in_port change to edgecapture being set SHALL be 3 clk edges.
REQ-028 The edgecapture bit SHALL be set on edge, and cleared by writing 1 to that bit at address 3; writing 0 SHALL leave the bit unchanged.
REQ-029 If an edge and a write-1-clear hit the same bit in the same cycle, the set SHALL win.
REQ-030 irq SHALL be registered: irq <= |(src & irqmask), where src = edgecapture when IRQ_TYPE=1 and src = sync_in when IRQ_TYPE=0.
REQ-031 The direction register SHALL drive oe directly; out_port SHALL always equal data_out, regardless of direction.
REQ-032 Bits of edgecapture SHALL be set whether or not direction=1 for that bit (software masks as needed).

Reset
REQ-033 Asserting reset SHALL immediately set data_out to RESET_VALUE and set direction, irqmask, edgecapture, sync_in, prev_in and irq to 0.
REQ-034 Reset asserted mid-operation SHALL discard pending captures and in-flight synchroniser state.
REQ-035 No edge SHALL be reported in the first cycle after release solely because of the reset values.
REQ-036 The first 3 cycles after reset release SHALL compare against sync/prev values of 0 (a high in_port at release is a rising edge).

Structure
REQ-037 Package system_gpio_pkg SHALL hold the register address constants and the EDGE_TYPE/IRQ_TYPE encodings.
REQ-038 Sub-module system_gpio_sync SHALL implement the WIDTH-wide 2-flop synchroniser, prev flop and edge detect, and output sync_in and edge.
REQ-039 The top level SHALL hold the register file, read mux and irq.

Verification
REQ-040 Bench scenario: WIDTH=19, reset, read address 0 with direction=0 and in_port=0 -> readdata=0, out_port=RESET_VALUE, irq=0.
REQ-041 Bench scenario: write data 0x00F0, outset 0x0003, then outclear 0x0010 -> out_port=0x00E3 one cycle after each write, with data readback 0x00E3 when direction=0x7FFFF.
REQ-042 Bench scenario: EDGE_TYPE=0, irqmask=0x1, in_port[0] 0->1 -> edgecapture[0]=1 after 3 edges and irq=1 one cycle later; write 0x1 to address 3 -> irq=0 in the following cycle.
REQ-043 Bench scenario: an edge on bit 2 in the same cycle as a write-1-clear to bit 2 -> edgecapture[2] remains 1.
REQ-044 Bench scenario: IRQ_TYPE=0, irqmask=0x4, in_port[2] held high -> irq=1; drop in_port[2] -> irq=0 three cycles later.
REQ-045 Bench scenario: assert reset while edgecapture=0x5 and data_out=0x123 -> both clear to 0/RESET_VALUE asynchronously, before the next clk edge.
